// File: rtl/mem_wait_responder_pkg.sv
// Shared definitions for the memory wait-state responder: size codes,
// read/write polarity, FSM state type and small decode helpers.
package mem_wait_responder_pkg;

  localparam logic [2:0] MS_BYTE  = 3'b000;
  localparam logic [2:0] MS_HALF  = 3'b001;
  localparam logic [2:0] MS_WORD  = 3'b010;
  localparam logic [2:0] MS_SBYTE = 3'b100;
  localparam logic [2:0] MS_SHALF = 3'b101;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for the five size codes the responder understands.
  function automatic logic ms_is_legal(input logic [2:0] ms);
    return (ms == MS_BYTE) || (ms == MS_HALF) || (ms == MS_WORD) ||
           (ms == MS_SBYTE) || (ms == MS_SHALF);
  endfunction

  // True for the sign-extending read codes.
  function automatic logic ms_is_signed(input logic [2:0] ms);
    return (ms == MS_SBYTE) || (ms == MS_SHALF);
  endfunction

endpackage

// File: rtl/mem_wait_responder_if.sv
// MOV/READWRITE/MS/MOC memory handshake bundle between the CPU control
// unit (master) and the memory responder (slave).
interface mem_wait_responder_if #(
  parameter int ADDR_W = 8
);

  logic              mov;
  logic              read_write;
  logic [2:0]        ms;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              moc;
  logic              ms_err;

  modport master (
    output mov,
    output read_write,
    output ms,
    output addr,
    output data_in,
    input  data_out,
    input  moc,
    input  ms_err
  );

  modport slave (
    input  mov,
    input  read_write,
    input  ms,
    input  addr,
    input  data_in,
    output data_out,
    output moc,
    output ms_err
  );

endinterface

// File: rtl/mem_wait_responder_lane_fmt.sv
// Combinational lane formatter: given the size code, the low address bits
// and the four bytes of the enclosing aligned word (fetch[0] is the most
// significant, lowest-addressed byte), produce the extended read data, the
// per-byte write enables and write data, and the error flag.
module mem_wait_responder_lane_fmt
  import mem_wait_responder_pkg::*;
(
  input  logic [2:0]       ms,
  input  logic [1:0]       addr_lo,
  input  logic [3:0][7:0]  fetch,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [3:0]       lane_we,
  output logic [3:0][7:0]  lane_wdata,
  output logic             ms_err
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [1:0]  hi_idx;
  logic [1:0]  lo_idx;
  logic        sext;

  // Decode size code into lane selection, extension and error; illegal codes
  // read the whole word, enable no lanes and always flag an error.
  always_comb begin
    rdata      = '0;
    lane_we    = '0;
    lane_wdata = '0;
    ms_err     = 1'b0;
    sel_byte   = '0;
    sel_half   = '0;
    hi_idx     = {addr_lo[1], 1'b0};
    lo_idx     = {addr_lo[1], 1'b1};
    sext       = ms_is_signed(ms);
    case (ms)
      MS_BYTE, MS_SBYTE: begin
        sel_byte            = fetch[addr_lo];
        rdata               = {{24{sext & sel_byte[7]}}, sel_byte};
        lane_we[addr_lo]    = 1'b1;
        lane_wdata[addr_lo] = wdata[7:0];
      end
      MS_HALF, MS_SHALF: begin
        sel_half           = {fetch[hi_idx], fetch[lo_idx]};
        rdata              = {{16{sext & sel_half[15]}}, sel_half};
        lane_we[hi_idx]    = 1'b1;
        lane_we[lo_idx]    = 1'b1;
        lane_wdata[hi_idx] = wdata[15:8];
        lane_wdata[lo_idx] = wdata[7:0];
        ms_err             = addr_lo[0];
      end
      MS_WORD: begin
        rdata         = {fetch[0], fetch[1], fetch[2], fetch[3]};
        lane_we       = 4'hF;
        lane_wdata[0] = wdata[31:24];
        lane_wdata[1] = wdata[23:16];
        lane_wdata[2] = wdata[15:8];
        lane_wdata[3] = wdata[7:0];
        ms_err        = (addr_lo != 2'b00);
      end
      default: begin
        rdata  = {fetch[0], fetch[1], fetch[2], fetch[3]};
        ms_err = ~ms_is_legal(ms);
      end
    endcase
  end

endmodule

// File: rtl/mem_wait_responder.sv
// Memory-side responder for the CPU MOV/MOC handshake: a big-endian,
// byte-addressed store that completes each access after a fixed number of
// wait states. The FSM, wait counter, captured request and the byte array
// live here; lane steering and extension are in the lane formatter.
module mem_wait_responder
  import mem_wait_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_wait_responder_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [7:0]        memory [0:DEPTH-1];

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              rw_q;
  logic [2:0]        ms_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  logic              acc_rw;
  logic [2:0]        acc_ms;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              do_access;

  logic [3:0][7:0]   fetch;
  logic [31:0]       fmt_rdata;
  logic [3:0]        fmt_we;
  logic [3:0][7:0]   fmt_wdata;
  logic              fmt_err;

  // With zero wait states the access happens on the accepting edge, so the
  // live bus request is used in IDLE; otherwise the captured copy is used.
  assign acc_rw    = (state == ST_IDLE) ? bus.read_write : rw_q;
  assign acc_ms    = (state == ST_IDLE) ? bus.ms         : ms_q;
  assign acc_addr  = (state == ST_IDLE) ? bus.addr       : addr_q;
  assign acc_wdata = (state == ST_IDLE) ? bus.data_in    : wdata_q;

  assign do_access = bus.mov &&
                     (((state == ST_IDLE) && (WAIT_CYCLES == 0)) ||
                      ((state == ST_BUSY) && (cnt == '0)));

  // Fetch the four bytes of the aligned word enclosing the access address.
  always_comb begin
    fetch = '0;
    for (int i = 0; i < 4; i++) begin
      fetch[i] = memory[{acc_addr[ADDR_W-1:2], 2'(i)}];
    end
  end

  mem_wait_responder_lane_fmt u_lane_fmt (
    .ms         (acc_ms),
    .addr_lo    (acc_addr[1:0]),
    .fetch      (fetch),
    .wdata      (acc_wdata),
    .rdata      (fmt_rdata),
    .lane_we    (fmt_we),
    .lane_wdata (fmt_wdata),
    .ms_err     (fmt_err)
  );

  // Handshake FSM with wait counter, request capture, registered MOC/MS_ERR
  // and the byte-lane memory update; memory contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      rw_q         <= RW_READ;
      ms_q         <= MS_BYTE;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      bus.moc      <= 1'b0;
      bus.ms_err   <= 1'b0;
      bus.data_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.mov) begin
            rw_q    <= bus.read_write;
            ms_q    <= bus.ms;
            addr_q  <= bus.addr;
            wdata_q <= bus.data_in;
            if (WAIT_CYCLES != 0) begin
              state <= ST_BUSY;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_BUSY: begin
          if (!bus.mov) begin
            state <= ST_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.mov) begin
            bus.moc    <= 1'b1;
            bus.ms_err <= err_q;
          end else begin
            bus.moc    <= 1'b0;
            bus.ms_err <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (do_access) begin
        state <= ST_DONE;
        err_q <= fmt_err;
        if (acc_rw == RW_READ) begin
          bus.data_out <= fmt_rdata;
        end
        for (int i = 0; i < 4; i++) begin
          if ((acc_rw == RW_WRITE) && fmt_we[i]) begin
            memory[{acc_addr[ADDR_W-1:2], 2'(i)}] <= fmt_wdata[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Randomised scoreboard bench for mem_wait_responder. Two instances are
// driven: index 0 with zero wait states, index 1 with two. A byte-array
// reference model computes each expected response when the request is
// issued; a monitor pops and compares when MOC rises.
module tb_mem_wait_responder;
  import mem_wait_responder_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        mov_r  [2];
  logic        rw_r   [2];
  logic [2:0]  ms_r   [2];
  logic [7:0]  addr_r [2];
  logic [31:0] din_r  [2];
  logic        moc_w  [2];
  logic        err_w  [2];
  logic [31:0] dout_w [2];
  logic        moc_prev [2] = '{1'b0, 1'b0};

  logic [7:0]  ref_mem [2][256];
  logic [31:0] last_read [2];
  exp_t        sb0 [$];
  exp_t        sb1 [$];

  mem_wait_responder_if #(.ADDR_W(8)) bus0 ();
  mem_wait_responder_if #(.ADDR_W(8)) bus1 ();

  assign bus0.mov        = mov_r[0];
  assign bus0.read_write = rw_r[0];
  assign bus0.ms         = ms_r[0];
  assign bus0.addr       = addr_r[0];
  assign bus0.data_in    = din_r[0];
  assign bus1.mov        = mov_r[1];
  assign bus1.read_write = rw_r[1];
  assign bus1.ms         = ms_r[1];
  assign bus1.addr       = addr_r[1];
  assign bus1.data_in    = din_r[1];
  assign moc_w[0]  = bus0.moc;
  assign err_w[0]  = bus0.ms_err;
  assign dout_w[0] = bus0.data_out;
  assign moc_w[1]  = bus1.moc;
  assign err_w[1]  = bus1.ms_err;
  assign dout_w[1] = bus1.data_out;

  mem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  mem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  // Free-running clock and edge counter used for latency expectations.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: apply one access to the byte array and return the
  // response the responder must show when MOC rises.
  function automatic exp_t model_access(input int d, input logic rw, input logic [2:0] ms,
                                        input logic [7:0] a, input logic [31:0] wd);
    exp_t e;
    bit   legal;
    int   base;
    int   v;
    legal = (ms == 3'b000) || (ms == 3'b001) || (ms == 3'b010) ||
            (ms == 3'b100) || (ms == 3'b101);
    e.err = 1'b0;
    e.edge_no = 0;
    if (legal && (ms == 3'b000 || ms == 3'b100)) begin
      v = int'(ref_mem[d][a]);
      if (ms == 3'b100 && v >= 128) v = v - 256;
      e.data = v;
      if (rw == 1'b0) ref_mem[d][a] = wd[7:0];
    end else if (legal && (ms == 3'b001 || ms == 3'b101)) begin
      base = int'(a) - (int'(a) % 2);
      v = int'(ref_mem[d][base]) * 256 + int'(ref_mem[d][base + 1]);
      if (ms == 3'b101 && v >= 32768) v = v - 65536;
      e.data = v;
      e.err = (int'(a) % 2) != 0;
      if (rw == 1'b0) begin
        ref_mem[d][base]     = wd[15:8];
        ref_mem[d][base + 1] = wd[7:0];
      end
    end else begin
      base = int'(a) - (int'(a) % 4);
      e.data = {ref_mem[d][base], ref_mem[d][base + 1], ref_mem[d][base + 2], ref_mem[d][base + 3]};
      e.err = !legal || ((int'(a) % 4) != 0);
      if (rw == 1'b0 && legal) begin
        ref_mem[d][base]     = wd[31:24];
        ref_mem[d][base + 1] = wd[23:16];
        ref_mem[d][base + 2] = wd[15:8];
        ref_mem[d][base + 3] = wd[7:0];
      end
    end
    if (rw == 1'b1) last_read[d] = e.data;
    else e.data = last_read[d];
    return e;
  endfunction

  // Issue one complete handshake; request fields are scrambled after
  // acceptance and MOV is held for 'hold' extra cycles after MOC.
  task automatic applyStimulus(input int d, input logic rw, input logic [2:0] ms,
                               input logic [7:0] a, input logic [31:0] wd, input int hold,
                               input bit use_want = 1'b0, input logic [31:0] want = 32'h0);
    exp_t e;
    int   waited;
    @(negedge clk);
    e = model_access(d, rw, ms, a, wd);
    if (use_want) e.data = want;
    e.edge_no = cyc + 2 + wait_of(d);
    if (d == 0) sb0.push_back(e);
    else sb1.push_back(e);
    mov_r[d] = 1'b1; rw_r[d] = rw; ms_r[d] = ms; addr_r[d] = a; din_r[d] = wd;
    @(negedge clk);
    rw_r[d] = 1'($urandom); ms_r[d] = 3'($urandom); addr_r[d] = 8'($urandom); din_r[d] = $urandom;
    waited = 0;
    while (!moc_w[d] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!moc_w[d]) begin
      checkOutput($sformatf("moc_timeout_d%0d", d), 32'(moc_w[d]), 32'd1);
      if (d == 0 && sb0.size() > 0) void'(sb0.pop_back());
      if (d == 1 && sb1.size() > 0) void'(sb1.pop_back());
    end else begin
      repeat (hold) begin
        @(negedge clk);
        checkOutput($sformatf("moc_hold_d%0d", d), 32'(moc_w[d]), 32'd1);
      end
    end
    mov_r[d] = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("moc_drop_d%0d", d), 32'(moc_w[d]), 32'd0);
    checkOutput($sformatf("err_drop_d%0d", d), 32'(err_w[d]), 32'd0);
  endtask

  // Start a request and withdraw MOV while the responder is still waiting.
  task automatic abortAccess(input int d, input logic rw, input logic [2:0] ms,
                             input logic [7:0] a, input logic [31:0] wd);
    @(negedge clk);
    mov_r[d] = 1'b1; rw_r[d] = rw; ms_r[d] = ms; addr_r[d] = a; din_r[d] = wd;
    @(negedge clk);
    mov_r[d] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checkOutput($sformatf("abort_no_moc_d%0d", d), 32'(moc_w[d]), 32'd0);
    end
  endtask

  task automatic popCompare(input int d);
    exp_t e;
    if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_moc_d%0d actual=moc_high required=no_pending_request", d);
    end else begin
      if (d == 0) e = sb0.pop_front();
      else e = sb1.pop_front();
      checkOutput($sformatf("data_out_d%0d", d), dout_w[d], e.data);
      checkOutput($sformatf("ms_err_d%0d", d), 32'(err_w[d]), 32'(e.err));
      checkOutput($sformatf("moc_latency_d%0d", d), 32'(cyc), 32'(e.edge_no));
    end
  endtask

  // Monitor: compare against the scoreboard whenever MOC rises.
  always @(negedge clk) begin
    if (moc_w[0] && !moc_prev[0]) popCompare(0);
    if (moc_w[1] && !moc_prev[1]) popCompare(1);
    moc_prev[0] <= moc_w[0];
    moc_prev[1] <= moc_w[1];
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    for (int d = 0; d < 2; d++) begin
      mov_r[d] = 1'b0; rw_r[d] = RW_READ; ms_r[d] = MS_BYTE; addr_r[d] = '0; din_r[d] = '0;
      last_read[d] = '0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset_moc", 32'(moc_w[1]), 32'd0);
    checkOutput("reset_err", 32'(err_w[1]), 32'd0);
    checkOutput("reset_dout", dout_w[1], 32'd0);
    checkOutput("reset_dout_d0", dout_w[0], 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) begin
      applyStimulus(1, RW_WRITE, MS_WORD, 8'(i * 4), $urandom, 0);
      applyStimulus(0, RW_WRITE, MS_WORD, 8'(i * 4), $urandom, 0);
    end

    applyStimulus(1, RW_WRITE, MS_WORD, 8'h20, 32'h12345678, 0);
    applyStimulus(1, RW_READ,  MS_WORD, 8'h20, $urandom, 0, 1'b1, 32'h12345678);

    applyStimulus(1, RW_WRITE, MS_BYTE,  8'h31, 32'h0000009A, 0);
    applyStimulus(1, RW_READ,  MS_SBYTE, 8'h31, $urandom, 0, 1'b1, 32'hFFFFFF9A);
    applyStimulus(1, RW_READ,  MS_BYTE,  8'h31, $urandom, 0, 1'b1, 32'h0000009A);
    applyStimulus(1, RW_WRITE, MS_HALF,  8'h30, 32'h00008001, 0);
    applyStimulus(1, RW_READ,  MS_SHALF, 8'h30, $urandom, 0, 1'b1, 32'hFFFF8001);
    applyStimulus(1, RW_READ,  MS_HALF,  8'h30, $urandom, 0, 1'b1, 32'h00008001);

    applyStimulus(1, RW_WRITE, MS_WORD, 8'h40, 32'hAABBCCDD, 0);
    applyStimulus(1, RW_WRITE, MS_BYTE, 8'h42, 32'h00000011, 0);
    applyStimulus(1, RW_READ,  MS_WORD, 8'h40, $urandom, 0, 1'b1, 32'hAABB11DD);

    applyStimulus(1, RW_READ,  MS_WORD, 8'h21, $urandom, 0, 1'b1, 32'h12345678);
    applyStimulus(1, RW_WRITE, 3'b111,  8'h50, 32'hDEADBEEF, 0);
    applyStimulus(1, RW_READ,  MS_WORD, 8'h50, $urandom, 0);
    applyStimulus(1, RW_READ,  MS_BYTE, 8'hFF, $urandom, 0);
    applyStimulus(1, RW_WRITE, MS_WORD, 8'hFC, 32'h0BADF00D, 0);
    applyStimulus(1, RW_READ,  MS_WORD, 8'hFC, $urandom, 0, 1'b1, 32'h0BADF00D);

    abortAccess(1, RW_WRITE, MS_WORD, 8'h60, 32'hCAFEBABE);
    applyStimulus(1, RW_READ, MS_WORD, 8'h60, $urandom, 0);
    applyStimulus(1, RW_READ, MS_WORD, 8'h40, $urandom, 5, 1'b1, 32'hAABB11DD);

    applyStimulus(0, RW_WRITE, MS_WORD,  8'h08, 32'hCAFEF00D, 0);
    applyStimulus(0, RW_READ,  MS_WORD,  8'h08, $urandom, 3, 1'b1, 32'hCAFEF00D);
    applyStimulus(0, RW_READ,  MS_SHALF, 8'h0A, $urandom, 0, 1'b1, 32'hFFFFF00D);

    applyStimulus(1, RW_READ, MS_BYTE, 8'h31, $urandom, 0);
    @(negedge clk);
    mov_r[1] = 1'b1; rw_r[1] = RW_WRITE; ms_r[1] = MS_BYTE; addr_r[1] = 8'h10; din_r[1] = 32'h000000E7;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_moc", 32'(moc_w[1]), 32'd0);
    checkOutput("midreset_dout", dout_w[1], 32'd0);
    mov_r[1] = 1'b0;
    last_read[0] = '0;
    last_read[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, RW_WRITE, MS_WORD, 8'h70, $urandom, 0);
    checkOutput("postreset_dout", dout_w[1], 32'd0);
    applyStimulus(1, RW_READ, MS_BYTE, 8'h10, $urandom, 0);

    repeat (150) begin
      applyStimulus(1, 1'($urandom), 3'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 2)));
    end
    repeat (40) begin
      applyStimulus(0, 1'($urandom), 3'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 2)));
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb0.size() + sb1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
